// File: rtl/vdp_priority_compute_n.sv
// VDP layer priority resolver: NUM_SCROLL scroll layers plus one sprite layer.
// Picks the highest-ranked opaque primary and masked layer per pixel through a
// 2-stage valid-qualified pipeline. Enable/mask config is double-buffered and
// only changes when config_load is strobed.

// Per-layer classification: opacity test, set membership, and rank tuple.
module vdp_prio_layer #(
  parameter int OPACITY_BITS = 4,
  parameter int LVL_W        = 2
) (
  input  logic [OPACITY_BITS-1:0] opq_bits,
  input  logic                    en,
  input  logic                    sel,
  input  logic [LVL_W-1:0]        level,
  input  logic                    is_sprite,
  output logic                    prim,
  output logic                    mskd,
  output logic [LVL_W+1:0]        rank
);
  logic opaque;
  assign opaque = |opq_bits;
  assign prim   = en & opaque & sel;
  assign mskd   = en & opaque & ~sel;
  // Leading 1 keeps any real layer above the all-zero "no layer" rank; the
  // trailing sprite bit lets the sprite win a tie at the same level.
  assign rank   = {1'b1, level, is_sprite};
endmodule

module vdp_priority_compute_n #(
  parameter int NUM_SCROLL   = 4,
  parameter int PIXEL_WIDTH  = 8,
  parameter int OPACITY_BITS = 4,
  parameter int PRIO_BITS    = 2,
  localparam int L           = NUM_SCROLL + 1
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              pixel_valid,
  input  logic [NUM_SCROLL*PIXEL_WIDTH-1:0] scroll_pixels,
  input  logic [PIXEL_WIDTH-1:0]            sprite_pixel,
  input  logic [PRIO_BITS-1:0]              sprite_priority,
  input  logic [L-1:0]                      layer_enable_shadow,
  input  logic [L-1:0]                      layer_mask_shadow,
  input  logic                              config_load,
  output logic                              out_valid,
  output logic [PIXEL_WIDTH-1:0]            prioritized_pixel,
  output logic [L-1:0]                      prioritized_layer,
  output logic [PIXEL_WIDTH-1:0]            prioritized_masked_pixel,
  output logic [L-1:0]                      prioritized_masked_layer
);
  localparam int LVL_W = (NUM_SCROLL > 1) ? $clog2(NUM_SCROLL) : 1;
  localparam int RW    = LVL_W + 2;

  logic [L-1:0]                  en_act, mask_act;
  logic [L-1:0][PIXEL_WIDTH-1:0] lpix;
  logic [L-1:0][LVL_W-1:0]       lvl;
  logic [L-1:0][RW-1:0]          rank;
  logic [L-1:0]                  prim, mskd;
  logic [LVL_W-1:0]              spr_lvl;

  // Combinational winners
  logic [L-1:0]           p_oh, m_oh;
  logic [PIXEL_WIDTH-1:0] p_pix, m_pix;
  logic [RW-1:0]          p_rank, m_rank;

  // Stage 1 registers
  logic                   s1_valid;
  logic [L-1:0]           s1_p_oh, s1_m_oh;
  logic [PIXEL_WIDTH-1:0] s1_p_pix, s1_m_pix;
  logic [RW-1:0]          s1_p_rank, s1_m_rank;

  // Sprite level saturates at the top scroll level.
  always_comb begin
    if (int'(sprite_priority) > NUM_SCROLL - 1) spr_lvl = LVL_W'(NUM_SCROLL - 1);
    else                                         spr_lvl = LVL_W'(sprite_priority);
  end

  // Unpack layers: scroll i has level NUM_SCROLL-1-i, sprite sits at the top index.
  for (genvar i = 0; i < NUM_SCROLL; i++) begin : g_scroll
    assign lpix[i] = scroll_pixels[i*PIXEL_WIDTH +: PIXEL_WIDTH];
    assign lvl[i]  = LVL_W'(NUM_SCROLL - 1 - i);
  end
  assign lpix[L-1] = sprite_pixel;
  assign lvl[L-1]  = spr_lvl;

  for (genvar k = 0; k < L; k++) begin : g_layer
    vdp_prio_layer #(.OPACITY_BITS(OPACITY_BITS), .LVL_W(LVL_W)) u_layer (
      .opq_bits (lpix[k][OPACITY_BITS-1:0]),
      .en       (en_act[k]),
      .sel      (mask_act[k]),
      .level    (lvl[k]),
      .is_sprite(k == L - 1),
      .prim     (prim[k]),
      .mskd     (mskd[k]),
      .rank     (rank[k])
    );
  end

  // Max-rank search over each set; ranks are unique so the winner is one-hot.
  always_comb begin
    p_oh = '0; p_pix = '0; p_rank = '0;
    m_oh = '0; m_pix = '0; m_rank = '0;
    for (int k = 0; k < L; k++) begin
      if (prim[k] && rank[k] > p_rank) begin
        p_rank = rank[k]; p_pix = lpix[k]; p_oh = '0; p_oh[k] = 1'b1;
      end
      if (mskd[k] && rank[k] > m_rank) begin
        m_rank = rank[k]; m_pix = lpix[k]; m_oh = '0; m_oh[k] = 1'b1;
      end
    end
  end

  // Active config: shadow copied only on the load strobe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      en_act   <= '0;
      mask_act <= '0;
    end else if (config_load) begin
      en_act   <= layer_enable_shadow;
      mask_act <= layer_mask_shadow;
    end
  end

  // Stage 1: capture winners on valid pixels; data holds across bubbles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid  <= 1'b0;
      s1_p_oh   <= '0; s1_p_pix <= '0; s1_p_rank <= '0;
      s1_m_oh   <= '0; s1_m_pix <= '0; s1_m_rank <= '0;
    end else begin
      s1_valid <= pixel_valid;
      if (pixel_valid) begin
        s1_p_oh <= p_oh; s1_p_pix <= p_pix; s1_p_rank <= p_rank;
        s1_m_oh <= m_oh; s1_m_pix <= m_pix; s1_m_rank <= m_rank;
      end
    end
  end

  // Stage 2: publish outputs, suppressing a masked winner the primary outranks.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid                <= 1'b0;
      prioritized_layer        <= '0;
      prioritized_pixel        <= '0;
      prioritized_masked_layer <= '0;
      prioritized_masked_pixel <= '0;
    end else begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        prioritized_layer <= s1_p_oh;
        prioritized_pixel <= s1_p_pix;
        if (s1_p_rank > s1_m_rank) begin
          prioritized_masked_layer <= '0;
          prioritized_masked_pixel <= '0;
        end else begin
          prioritized_masked_layer <= s1_m_oh;
          prioritized_masked_pixel <= s1_m_pix;
        end
      end
    end
  end
endmodule
